// File: rtl/hash_table_pkg.sv
// Shared hash-table types and constants: table geometry, the data-RAM entry
// layout and the read-client numbering used by the data-table engines.
package hash_table;

  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;

  localparam int RD_CLIENTS       = 3;
  localparam int RD_CLIENT_SEARCH = 0;
  localparam int RD_CLIENT_INSERT = 1;
  localparam int RD_CLIENT_DELETE = 2;

  typedef struct packed {
    logic                        valid;
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
  } ram_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and wraps, and
// yields a one-hot grant plus its index. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int CLIENTS = 3,
  localparam int PW = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [CLIENTS-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               grant_vld
);

  int idx;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < CLIENTS; k++) begin
      idx = (int'(ptr) + k) % CLIENTS;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/data_table_rd_arbiter.sv
// Read-port responder for the data RAM: round-robin grants across the engines,
// one outstanding read per client, returned data tagged with a one-hot strobe.
module data_table_rd_arbiter
  import hash_table::*;
#(
  parameter int CLIENTS     = RD_CLIENTS,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int RAM_LATENCY = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CLIENTS-1:0]              rd_en_i,
  input  logic [CLIENTS-1:0][A_WIDTH-1:0] rd_addr_i,
  output logic [CLIENTS-1:0]              rd_avail_o,
  output ram_data_t                       rd_data_o,
  output logic [CLIENTS-1:0]              rd_data_val_o,
  input  logic                            ram_busy_i,
  output logic                            ram_rd_en_o,
  output logic [A_WIDTH-1:0]              ram_rd_addr_o,
  input  ram_data_t                       ram_rd_data_i
);

  localparam int PW = $clog2(CLIENTS);

  logic [CLIENTS-1:0]     inflight;
  logic [CLIENTS-1:0]     req;
  logic [CLIENTS-1:0]     grant;
  logic [PW-1:0]          grant_idx;
  logic                   grant_vld;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          req_id;
  logic [RAM_LATENCY-1:0] pipe_vld;
  logic [PW-1:0]          pipe_id [RAM_LATENCY];

  // Availability comes from registers and ram_busy_i only, never from rd_en_i.
  assign rd_avail_o = ~inflight & {CLIENTS{~ram_busy_i}};
  assign req        = rd_en_i & rd_avail_o;

  rr_arbiter #(.CLIENTS(CLIENTS)) u_rr_arbiter (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (grant_vld)
        rr_ptr <= (grant_idx == PW'(CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
      inflight <= (inflight | grant) & ~rd_data_val_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_rd_en_o   <= 1'b0;
      ram_rd_addr_o <= '0;
      req_id        <= '0;
    end else begin
      ram_rd_en_o <= grant_vld;
      if (grant_vld) begin
        ram_rd_addr_o <= rd_addr_i[grant_idx];
        req_id        <= grant_idx;
      end
    end
  end

  // NOTE: the id array is reset along with the valid bits; only valid bits gate
  // behaviour, but a flushed pipe then carries no stale ids into the next run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0] <= ram_rd_en_o;
      pipe_id[0]  <= req_id;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o     <= '0;
      rd_data_val_o <= '0;
    end else begin
      rd_data_val_o <= '0;
      if (pipe_vld[RAM_LATENCY-1]) begin
        rd_data_o     <= ram_rd_data_i;
        rd_data_val_o <= {{(CLIENTS-1){1'b0}}, 1'b1} << pipe_id[RAM_LATENCY-1];
      end
    end
  end

  a_val_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rd_data_val_o));

  a_no_grant_inflight : assert property (@(posedge clk_i) disable iff (rst_i)
    (grant & inflight) == '0);

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Directed bench for data_table_rd_arbiter with a two-cycle RAM model whose
// contents are a fixed function of the address.
module tb_data_table_rd_arbiter;
  import hash_table::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0]       rd_en_i;
  logic [2:0][7:0]  rd_addr_i;
  logic [2:0]       rd_avail_o;
  ram_data_t        rd_data_o;
  logic [2:0]       rd_data_val_o;
  logic             ram_busy_i;
  logic             ram_rd_en_o;
  logic [7:0]       ram_rd_addr_o;
  ram_data_t        ram_rd_data_i = '0;

  int errors = 0;
  int checks = 0;

  data_table_rd_arbiter #(.CLIENTS(3), .A_WIDTH(8), .RAM_LATENCY(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_en_i       (rd_en_i),
    .rd_addr_i     (rd_addr_i),
    .rd_avail_o    (rd_avail_o),
    .rd_data_o     (rd_data_o),
    .rd_data_val_o (rd_data_val_o),
    .ram_busy_i    (ram_busy_i),
    .ram_rd_en_o   (ram_rd_en_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .ram_rd_data_i (ram_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic ram_data_t mk_entry(input logic [7:0] a);
    ram_data_t d;
    d          = '0;
    d.valid    = 1'b1;
    d.key      = {8'h00, a ^ 8'hBE};
    d.value    = {8'hC0, a};
    d.next_ptr = a + 8'd1;
    return d;
  endfunction

  // RAM model: strobe in cycle c, data valid in c+2; not affected by rst_i.
  logic       s1_vld = 1'b0;
  logic [7:0] s1_addr = '0;
  always @(posedge clk_i) begin
    s1_vld  <= ram_rd_en_o;
    s1_addr <= ram_rd_addr_o;
    if (s1_vld) ram_rd_data_i <= mk_entry(s1_addr);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    rst_i      = 1'b1;
    rd_en_i    = '0;
    rd_addr_i  = '0;
    ram_busy_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i      = 1'b1;
    rd_en_i    = '0;
    rd_addr_i  = '0;
    ram_busy_i = 1'b0;
    #2;
    checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_ram_rd_en got=%b exp=0", ram_rd_en_o); end
    checks++; if (ram_rd_addr_o !== 8'h00) begin errors++; $display("FAIL reset_ram_rd_addr got=%h exp=00", ram_rd_addr_o); end
    checks++; if (rd_data_val_o !== 3'b000) begin errors++; $display("FAIL reset_rd_data_val got=%b exp=000", rd_data_val_o); end
    checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_o); end
    checks++; if (rd_avail_o !== 3'b111) begin errors++; $display("FAIL reset_avail got=%b exp=111", rd_avail_o); end
    ram_busy_i = 1'b1;
    #1;
    checks++; if (rd_avail_o !== 3'b000) begin errors++; $display("FAIL reset_avail_busy got=%b exp=000", rd_avail_o); end
    ram_busy_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    checks++; if (rd_avail_o !== 3'b111) begin errors++; $display("FAIL post_reset_avail got=%b exp=111", rd_avail_o); end
  endtask

  task automatic test_single_read;
    rd_en_i      = 3'b001;
    rd_addr_i[0] = 8'h15;
    tick();  // t+1
    rd_en_i = '0;
    checks++; if (ram_rd_en_o !== 1'b1) begin errors++; $display("FAIL single_ram_rd_en got=%b exp=1", ram_rd_en_o); end
    checks++; if (ram_rd_addr_o !== 8'h15) begin errors++; $display("FAIL single_ram_rd_addr got=%h exp=15", ram_rd_addr_o); end
    checks++; if (rd_avail_o[0] !== 1'b0) begin errors++; $display("FAIL single_avail_t1 got=%b exp=0", rd_avail_o[0]); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++; if (rd_avail_o[0] !== 1'b0 || rd_data_val_o !== 3'b000)
        begin errors++; $display("FAIL single_wait_t%0d avail0=%b val=%b exp avail0=0 val=000", c, rd_avail_o[0], rd_data_val_o); end
    end
    tick();  // t+4
    checks++; if (rd_data_val_o !== 3'b001) begin errors++; $display("FAIL single_val got=%b exp=001", rd_data_val_o); end
    checks++; if (rd_data_o.key !== 16'h00AB) begin errors++; $display("FAIL single_key got=%h exp=00ab", rd_data_o.key); end
    checks++; if (rd_avail_o[0] !== 1'b0) begin errors++; $display("FAIL single_avail_t4 got=%b exp=0", rd_avail_o[0]); end
    tick();  // t+5
    checks++; if (rd_avail_o[0] !== 1'b1 || rd_data_val_o !== 3'b000)
      begin errors++; $display("FAIL single_release avail0=%b val=%b exp avail0=1 val=000", rd_avail_o[0], rd_data_val_o); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    rd_en_i   = 3'b111;
    rd_addr_i = {8'h30, 8'h20, 8'h10};
    tick();  // t+1
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h10) begin errors++; $display("FAIL b2b_grant0 en=%b addr=%h exp en=1 addr=10", ram_rd_en_o, ram_rd_addr_o); end
    checks++; if (rd_avail_o !== 3'b110) begin errors++; $display("FAIL b2b_avail_t1 got=%b exp=110", rd_avail_o); end
    tick();  // t+2
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h20) begin errors++; $display("FAIL b2b_grant1 en=%b addr=%h exp en=1 addr=20", ram_rd_en_o, ram_rd_addr_o); end
    tick();  // t+3
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h30) begin errors++; $display("FAIL b2b_grant2 en=%b addr=%h exp en=1 addr=30", ram_rd_en_o, ram_rd_addr_o); end
    checks++; if (rd_avail_o !== 3'b000) begin errors++; $display("FAIL b2b_avail_t3 got=%b exp=000", rd_avail_o); end
    tick();  // t+4
    checks++; if (rd_data_val_o !== 3'b001 || rd_data_o.key !== 16'h00AE) begin errors++; $display("FAIL b2b_ret0 val=%b key=%h exp val=001 key=00ae", rd_data_val_o, rd_data_o.key); end
    checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_t4 got=%b exp=0", ram_rd_en_o); end
    tick();  // t+5: client 0 free again and still requesting
    checks++; if (rd_data_val_o !== 3'b010 || rd_data_o.key !== 16'h009E) begin errors++; $display("FAIL b2b_ret1 val=%b key=%h exp val=010 key=009e", rd_data_val_o, rd_data_o.key); end
    tick();  // t+6
    rd_en_i = '0;
    checks++; if (rd_data_val_o !== 3'b100 || rd_data_o.key !== 16'h008E) begin errors++; $display("FAIL b2b_ret2 val=%b key=%h exp val=100 key=008e", rd_data_val_o, rd_data_o.key); end
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h10) begin errors++; $display("FAIL b2b_round2 en=%b addr=%h exp en=1 addr=10", ram_rd_en_o, ram_rd_addr_o); end
    idle(8);
  endtask

  task automatic test_wrap;
    do_reset();
    rd_en_i      = 3'b010;
    rd_addr_i[1] = 8'h41;
    tick();
    checks++; if (ram_rd_addr_o !== 8'h41) begin errors++; $display("FAIL wrap_setup got=%h exp=41", ram_rd_addr_o); end
    rd_en_i      = 3'b101;
    rd_addr_i[0] = 8'h50;
    rd_addr_i[2] = 8'h52;
    tick();
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h52) begin errors++; $display("FAIL wrap_first en=%b addr=%h exp en=1 addr=52", ram_rd_en_o, ram_rd_addr_o); end
    tick();
    rd_en_i = '0;
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h50) begin errors++; $display("FAIL wrap_second en=%b addr=%h exp en=1 addr=50", ram_rd_en_o, ram_rd_addr_o); end
    idle(8);
    rd_en_i   = 3'b111;
    rd_addr_i = {8'h62, 8'h61, 8'h60};
    tick();
    rd_en_i = '0;
    checks++; if (ram_rd_addr_o !== 8'h61) begin errors++; $display("FAIL wrap_ptr_end got=%h exp=61", ram_rd_addr_o); end
    idle(8);
  endtask

  task automatic test_busy;
    do_reset();
    rd_en_i      = 3'b001;
    rd_addr_i[0] = 8'h07;
    tick();  // b+1
    rd_en_i      = 3'b010;
    rd_addr_i[1] = 8'h33;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      ram_busy_i = 1'b1;
      #1;
      checks++; if (rd_avail_o !== 3'b000) begin errors++; $display("FAIL busy_avail_%0d got=%b exp=000", i, rd_avail_o); end
      if (i >= 2) begin
        checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL busy_no_read_%0d got=%b exp=0", i, ram_rd_en_o); end
      end
      if (i == 4) begin
        checks++; if (rd_data_val_o !== 3'b001 || rd_data_o.key !== 16'h00B9) begin errors++; $display("FAIL busy_inflight_ret val=%b key=%h exp val=001 key=00b9", rd_data_val_o, rd_data_o.key); end
      end
    end
    tick();  // b+6: busy falls
    ram_busy_i = 1'b0;
    #1;
    checks++; if (rd_avail_o !== 3'b111 || ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL busy_fall avail=%b en=%b exp avail=111 en=0", rd_avail_o, ram_rd_en_o); end
    tick();  // b+7
    rd_en_i = '0;
    checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 8'h33) begin errors++; $display("FAIL busy_grant en=%b addr=%h exp en=1 addr=33", ram_rd_en_o, ram_rd_addr_o); end
    idle(8);
  endtask

  task automatic test_chain_walk;
    logic [7:0] hops [4];
    logic [15:0] exp_key;
    int reads;
    int hop;
    bit pending;
    hops    = '{8'h01, 8'h05, 8'h09, 8'h0D};
    reads   = 0;
    hop     = 0;
    pending = 1'b0;
    do_reset();
    rd_en_i      = 3'b001;
    rd_addr_i[0] = hops[0];
    for (int c = 0; c < 80 && hop < 4; c++) begin
      tick();
      if (pending) begin
        rd_addr_i[0] = hops[hop];
        pending      = 1'b0;
      end
      if (ram_rd_en_o) begin
        if (reads < 4) begin
          checks++; if (ram_rd_addr_o !== hops[reads]) begin errors++; $display("FAIL chain_addr_%0d got=%h exp=%h", reads, ram_rd_addr_o, hops[reads]); end
        end
        reads++;
      end
      if (rd_data_val_o[0]) begin
        exp_key = {8'h00, hops[hop] ^ 8'hBE};
        checks++; if (rd_data_o.key !== exp_key) begin errors++; $display("FAIL chain_key_%0d got=%h exp=%h", hop, rd_data_o.key, exp_key); end
        hop++;
        pending = 1'b1;
      end
    end
    rd_en_i = '0;
    checks++; if (hop != 4) begin errors++; $display("FAIL chain_timeout hops=%0d exp=4", hop); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ram_rd_en_o) reads++;
    end
    checks++; if (reads != 4) begin errors++; $display("FAIL chain_read_count got=%0d exp=4", reads); end
  endtask

  task automatic test_reset_mid_op;
    idle(2);
    rd_en_i      = 3'b001;
    rd_addr_i[0] = 8'h15;
    tick();  // t+1: read strobe out to RAM
    rd_en_i = '0;
    tick();  // t+2
    rst_i = 1'b1;
    #1;
    checks++; if (ram_rd_en_o !== 1'b0 || ram_rd_addr_o !== 8'h00) begin errors++; $display("FAIL midrst_req en=%b addr=%h exp en=0 addr=00", ram_rd_en_o, ram_rd_addr_o); end
    checks++; if (rd_data_val_o !== 3'b000 || rd_data_o !== '0) begin errors++; $display("FAIL midrst_resp val=%b data=%h exp val=000 data=0", rd_data_val_o, rd_data_o); end
    tick();  // t+3: RAM data for 0x15 arrives
    rst_i = 1'b0;
    #1;
    checks++; if (rd_avail_o !== 3'b111) begin errors++; $display("FAIL midrst_avail got=%b exp=111", rd_avail_o); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (rd_data_val_o !== 3'b000) begin errors++; $display("FAIL midrst_ghost_%0d got=%b exp=000", c, rd_data_val_o); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wrap();
    test_busy();
    test_chain_walk();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
